// File: rtl/inst_fetch.sv
// Instruction fetch stage: a PC register addresses a combinational instruction
// memory, and the returned word is latched into the IR together with the
// address it came from. Stall holds the stage, redirect steers the PC and
// flushes the IR, and halt freezes the stage until reset.
module inst_fetch #(
   parameter int          MEM_DEPTH = 128,
   parameter logic [31:0] RESET_PC  = 32'd0
) (
   input  logic        IFclk,
   input  logic        IFrst,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   input  logic        halt,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   output logic        addr_err
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ir_pc_q, ir_pc_d;
   logic        ir_valid_q, ir_valid_d;
   logic        addr_err_q, addr_err_d;

   // Address arithmetic is done on the low AW bits so the PC always stays
   // inside the memory; upper bits of a redirect target only raise addr_err.
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] redir_lo;
   logic          redir_oor;

   assign pc_inc    = pc_q[AW-1:0] + AW'(1'b1);
   assign redir_lo  = redirect_addr[AW-1:0];
   assign redir_oor = |redirect_addr[31:AW];

   // State register; reset always restarts from BOOT.
   always_ff @(posedge IFclk or posedge IFrst) begin
      if (IFrst) state_q <= BOOT;
      else       state_q <= state_d;
   end

   // Next state: BOOT lasts one cycle regardless of inputs, HALT is only left
   // by reset, otherwise halt beats redirect beats stall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN, HOLD: begin
            if (halt)          state_d = HALT;
            else if (redirect) state_d = RUN;
            else if (stall)    state_d = HOLD;
            else               state_d = RUN;
         end
         HALT:    state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   // Datapath next values chosen by state and the same priority order.
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      addr_err_d = addr_err_q;
      case (state_q)
         RUN, HOLD: begin
            if (halt) begin
               ir_valid_d = 1'b0;
            end else if (redirect) begin
               // Flush only the valid bit; ir/ir_pc keep their last contents.
               pc_d       = {{(32-AW){1'b0}}, redir_lo};
               ir_valid_d = 1'b0;
               addr_err_d = addr_err_q | redir_oor;
            end else if (!stall) begin
               ir_d       = inst;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               pc_d       = {{(32-AW){1'b0}}, pc_inc};
            end
         end
         default: ;
      endcase
   end

   // Datapath registers, cleared asynchronously by reset.
   always_ff @(posedge IFclk or posedge IFrst) begin
      if (IFrst) begin
         pc_q       <= RESET_PC;
         ir_q       <= 32'd0;
         ir_pc_q    <= 32'd0;
         ir_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign inst_addr = pc_q;
   assign ir        = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_valid  = ir_valid_q;
   assign addr_err  = addr_err_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 128: instruction memory depth in 32-bit words; a power of two.
REQ-002 SHALL have parameter RESET_PC, default 0: word address fetched first after reset.
REQ-003 SHALL have port IFclk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port IFrst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port inst_addr, output, 32: word address presented to the instruction memory; equals the PC register.
REQ-006 SHALL have port inst, input, 32: instruction word returned combinationally by the memory for inst_addr in the same cycle.
REQ-007 SHALL have port stall, input, 1: hold PC and IR this cycle.
REQ-008 SHALL have port redirect, input, 1: replace PC with redirect_addr and flush IR.
REQ-009 SHALL have port redirect_addr, input, 32: branch/jump target word address.
REQ-010 SHALL have port halt, input, 1: stop fetching until reset.
REQ-011 SHALL have port ir, output, 32: registered fetched instruction.
REQ-012 SHALL have port ir_pc, output, 32: word address ir was fetched from.
REQ-013 SHALL have port ir_valid, output, 1: ir/ir_pc hold a valid, unflushed instruction.
REQ-014 SHALL have port addr_err, output, 1: sticky flag; a redirect target was >= MEM_DEPTH.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, HOLD, HALT; BOOT is entered on reset.
REQ-016 SHALL spend exactly one cycle in BOOT with ir_valid=0, PC=RESET_PC, and no fetch latched, then enter RUN.
REQ-017 SHALL evaluate per-edge priority as: halt > redirect > stall > normal fetch.
REQ-018 SHALL, in RUN on a normal fetch: ir<=inst, ir_pc<=PC, ir_valid<=1, PC<=(PC+1) mod MEM_DEPTH.
REQ-019 SHALL wrap PC from MEM_DEPTH-1 to 0 with no error flag.
REQ-020 SHALL, in RUN with stall=1, enter HOLD with PC, ir, ir_pc and ir_valid unchanged.
REQ-021 SHALL remain in HOLD while stall=1 and return to RUN in the cycle stall=0, performing a normal fetch on that edge.
REQ-022 SHALL, on redirect=1 in RUN or HOLD, set PC<=redirect_addr mod MEM_DEPTH and ir_valid<=0, leave ir/ir_pc unchanged, and enter RUN; this overrides stall.
REQ-023 SHALL set addr_err<=1 if redirect is taken with redirect_addr >= MEM_DEPTH; addr_err SHALL clear only on reset.
REQ-024 SHALL deliver the first instruction from a redirect target with ir_valid=1 one edge after the redirect edge, i.e. one bubble.
REQ-025 SHALL, on halt=1 in any non-BOOT state, enter HALT, set ir_valid<=0, and freeze PC; HALT SHALL ignore stall and redirect and exit only via reset.
REQ-026 SHALL ignore stall, redirect and halt while in BOOT.
REQ-027 SHALL drive inst_addr directly from the PC register, which is stable the whole cycle.

Reset
REQ-028 SHALL, while IFrst=1 and regardless of clock, force state=BOOT, PC=RESET_PC, ir=0, ir_pc=0, ir_valid=0, addr_err=0.
REQ-029 SHALL, on reset asserted mid-operation including in HOLD or HALT, discard all in-flight state and restart from REQ-016.

Verification
REQ-030 SHALL test reset then free-run with memory[0..3]=A,B,C,D: after the BOOT cycle, ir=A/B/C/D with ir_pc=0/1/2/3 on consecutive edges and ir_valid=1.
REQ-031 SHALL test stall for 3 cycles while ir=B: ir=B, ir_pc=1 and inst_addr=2 held for 3 edges; next edge gives ir=C.
REQ-032 SHALL test redirect to 5 concurrent with stall=1: next edge ir_valid=0 and inst_addr=5; following edge ir=memory[5], ir_pc=5.
REQ-033 SHALL test free-running across the wrap: ir_pc=127 then ir_pc=0 with addr_err=0; redirect to 130 gives inst_addr=2 and addr_err=1.
REQ-034 SHALL test halt asserted with redirect=1: HALT entered, ir_valid=0, PC frozen, redirect ignored; asserting IFrst between clock edges gives all outputs zero immediately.
